// File: rtl/seq_det_pkg.sv
// Shared definitions for the serial sequence detector: FSM encoding, size defaults, length check.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package seq_det_pkg;

    localparam int MAX_LEN_DEF = 8;
    localparam int CNT_W_DEF   = 8;
    localparam int LEN_W       = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_RUN   = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // A length is usable when it selects at least one bit and no more than the history holds.
    function automatic logic len_legal(input logic [LEN_W-1:0] len, input int unsigned max_len);
        return (len != '0) && (32'(len) <= max_len);
    endfunction

endpackage

// File: rtl/pattern_match_core.sv
// Serial history shift register plus masked compare of the newest len bits against the pattern.
// Latency: hit is combinational on the incoming bit; history updates on the next rising edge.
// Backpressure: none; a bit is taken only when shift_en_i is high, clear_i takes priority.
module pattern_match_core
    import seq_det_pkg::*;
#(
    parameter int MAX_LEN = MAX_LEN_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               bit_i,
    input  logic               shift_en_i,
    input  logic               clear_i,
    input  logic [MAX_LEN-1:0] pattern_i,
    input  logic [LEN_W-1:0]   len_i,
    output logic               hit_o
);

    logic [MAX_LEN-1:0] hist_q;
    logic [MAX_LEN-1:0] hist_d;
    logic [MAX_LEN-1:0] cand;
    logic [MAX_LEN-1:0] mask;

    // Candidate history includes the bit being sampled now, so a match is seen on its last bit.
    always_comb begin
        cand = (hist_q << 1) | MAX_LEN'(bit_i);
        mask = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            mask[i] = (i < int'(len_i));
        end
        hit_o  = (((cand ^ pattern_i) & mask) == '0);
        hist_d = hist_q;
        if (clear_i) begin
            hist_d = '0;
        end else if (shift_en_i) begin
            hist_d = cand;
        end
    end

    // History register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            hist_q <= '0;
        end else begin
            hist_q <= hist_d;
        end
    end

endmodule

// File: rtl/seq_det_ctrl.sv
// Configurable serial pattern detector: config handshake, armed/run/done control, match counting.
// Latency: z pulses one cycle after the matching bit is sampled; err one cycle after a bad config.
// Backpressure: cfg_ready is high only in IDLE; x is taken only in RUN when x_valid is high.
module seq_det_ctrl
    import seq_det_pkg::*;
#(
    parameter int MAX_LEN = MAX_LEN_DEF,
    parameter int CNT_W   = CNT_W_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
    input  logic [CNT_W-1:0]   cfg_target,
    input  logic               start,
    input  logic               stop,
    input  logic               x,
    input  logic               x_valid,
    output logic               z,
    output logic [CNT_W-1:0]   match_cnt,
    output logic               busy,
    output logic               done,
    output logic               err
);

    localparam int BCW = $clog2(MAX_LEN + 1);

    state_e             state_q, state_d;
    logic [MAX_LEN-1:0] pat_q, pat_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic               ovl_q, ovl_d;
    logic [CNT_W-1:0]   tgt_q, tgt_d;
    logic [CNT_W-1:0]   mcnt_q, mcnt_d;
    logic [BCW-1:0]     bcnt_q, bcnt_d;
    logic               z_q, z_d;
    logic               err_q, err_d;

    logic               hit;
    logic               shift_en;
    logic               hist_clr;
    logic               enough_bits;
    logic               match;

    pattern_match_core #(
        .MAX_LEN (MAX_LEN)
    ) u_core (
        .clk        (clk),
        .reset      (reset),
        .bit_i      (x),
        .shift_en_i (shift_en),
        .clear_i    (hist_clr),
        .pattern_i  (pat_q),
        .len_i      (len_q),
        .hit_o      (hit)
    );

    // Next-state and datapath control; every run-time decision is made here.
    always_comb begin
        state_d     = state_q;
        pat_d       = pat_q;
        len_d       = len_q;
        ovl_d       = ovl_q;
        tgt_d       = tgt_q;
        mcnt_d      = mcnt_q;
        bcnt_d      = bcnt_q;
        z_d         = 1'b0;
        err_d       = 1'b0;
        shift_en    = 1'b0;
        hist_clr    = 1'b0;
        // The current bit counts toward the required length.
        enough_bits = ((int'(bcnt_q) + 1) >= int'(len_q));
        match       = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (cfg_valid) begin
                    if (len_legal(cfg_len, MAX_LEN)) begin
                        pat_d   = cfg_pattern;
                        len_d   = cfg_len;
                        ovl_d   = cfg_overlap;
                        tgt_d   = cfg_target;
                        mcnt_d  = '0;
                        state_d = ST_ARMED;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_ARMED: begin
                // An abort request outranks arming when both arrive together.
                if (stop) begin
                    state_d = ST_IDLE;
                end else if (start) begin
                    hist_clr = 1'b1;
                    bcnt_d   = '0;
                    state_d  = ST_RUN;
                end
            end
            ST_RUN: begin
                if (x_valid) begin
                    shift_en = 1'b1;
                    match    = enough_bits && hit;
                    if (bcnt_q != BCW'(MAX_LEN)) begin
                        bcnt_d = bcnt_q + 1'b1;
                    end
                    if (match) begin
                        z_d = 1'b1;
                        if (mcnt_q != '1) begin
                            mcnt_d = mcnt_q + 1'b1;
                        end
                        // Without overlap the next match must be built from fresh bits.
                        if (!ovl_q) begin
                            bcnt_d = '0;
                        end
                        if ((tgt_q != '0) && (mcnt_d == tgt_q)) begin
                            state_d = ST_DONE;
                        end
                    end
                end
                if (stop) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                // The cfg_valid that leaves DONE is not itself accepted (cfg_ready is low here).
                if (start || cfg_valid) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset overrides every other input.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            pat_q   <= '0;
            len_q   <= '0;
            ovl_q   <= 1'b0;
            tgt_q   <= '0;
            mcnt_q  <= '0;
            bcnt_q  <= '0;
            z_q     <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            len_q   <= len_d;
            ovl_q   <= ovl_d;
            tgt_q   <= tgt_d;
            mcnt_q  <= mcnt_d;
            bcnt_q  <= bcnt_d;
            z_q     <= z_d;
            err_q   <= err_d;
        end
    end

    assign cfg_ready = (state_q == ST_IDLE);
    assign busy      = (state_q == ST_RUN);
    assign done      = (state_q == ST_DONE);
    assign z         = z_q;
    assign err       = err_q;
    assign match_cnt = mcnt_q;

endmodule

// File: tb/tb_seq_det_ctrl.sv
// Directed bench for seq_det_ctrl with hand-computed expectations checked by immediate assertions.
// Latency: inputs change 1ns after a rising edge; outputs are checked 1ns after the next edge.
// Backpressure: n/a.
module tb_seq_det_ctrl;

    logic       clk;
    logic       reset;
    logic       cfg_valid;
    logic       cfg_ready;
    logic [7:0] cfg_pattern;
    logic [3:0] cfg_len;
    logic       cfg_overlap;
    logic [7:0] cfg_target;
    logic       start;
    logic       stop;
    logic       x;
    logic       x_valid;
    logic       z;
    logic [7:0] match_cnt;
    logic       busy;
    logic       done;
    logic       err;

    int vectors;
    int miscompares;

    seq_det_ctrl #(
        .MAX_LEN (8),
        .CNT_W   (8)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .cfg_pattern (cfg_pattern),
        .cfg_len     (cfg_len),
        .cfg_overlap (cfg_overlap),
        .cfg_target  (cfg_target),
        .start       (start),
        .stop        (stop),
        .x           (x),
        .x_valid     (x_valid),
        .z           (z),
        .match_cnt   (match_cnt),
        .busy        (busy),
        .done        (done),
        .err         (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_cfg(input logic [7:0] pat, input logic [3:0] len,
                          input logic ovl, input logic [7:0] tgt);
        cfg_pattern = pat;
        cfg_len     = len;
        cfg_overlap = ovl;
        cfg_target  = tgt;
        cfg_valid   = 1'b1;
        tick();
        cfg_valid   = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1;
        tick();
        stop = 1'b0;
    endtask

    task automatic send_bit(input logic b, input logic exp_z, input string tag);
        x       = b;
        x_valid = 1'b1;
        tick();
        x_valid = 1'b0;
        chk(tag, 32'(z), 32'(exp_z));
    endtask

    task automatic send_gap(input logic junk);
        x       = junk;
        x_valid = 1'b0;
        tick();
        chk("gap_z", 32'(z), 32'd0);
    endtask

    initial begin
        logic [6:0] stream;
        logic [6:0] z_no_ovl;
        logic [6:0] z_ovl;
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b1;
        cfg_valid   = 1'b0;
        cfg_pattern = '0;
        cfg_len     = '0;
        cfg_overlap = 1'b0;
        cfg_target  = '0;
        start       = 1'b0;
        stop        = 1'b0;
        x           = 1'b0;
        x_valid     = 1'b0;
        // Stream 0110110, first bit in position 6; expected z after each bit.
        stream   = 7'b0110110;
        z_no_ovl = 7'b0001000;
        z_ovl    = 7'b0001001;

        tick();
        tick();
        reset = 1'b0;
        chk("rst_ready", 32'(cfg_ready), 32'd1);
        chk("rst_busy",  32'(busy),      32'd0);
        chk("rst_done",  32'(done),      32'd0);
        chk("rst_z",     32'(z),         32'd0);
        chk("rst_err",   32'(err),       32'd0);
        chk("rst_cnt",   32'(match_cnt), 32'd0);

        // Non-overlapping 0110 on 0110110: single match on bit 4.
        do_cfg(8'b0110, 4'd4, 1'b0, 8'd0);
        chk("nov_armed_ready", 32'(cfg_ready), 32'd0);
        pulse_start();
        chk("nov_busy", 32'(busy), 32'd1);
        for (int i = 6; i >= 0; i--) begin
            send_bit(stream[i], z_no_ovl[i], "nov_z");
        end
        chk("nov_cnt", 32'(match_cnt), 32'd1);
        pulse_stop();
        chk("nov_stop_done", 32'(done), 32'd1);
        chk("nov_stop_cnt",  32'(match_cnt), 32'd1);
        pulse_start();
        chk("nov_back_idle", 32'(cfg_ready), 32'd1);

        // Overlapping: matches on bits 4 and 7.
        do_cfg(8'b0110, 4'd4, 1'b1, 8'd0);
        chk("ovl_cnt_clear", 32'(match_cnt), 32'd0);
        pulse_start();
        for (int i = 6; i >= 0; i--) begin
            send_bit(stream[i], z_ovl[i], "ovl_z");
        end
        chk("ovl_cnt", 32'(match_cnt), 32'd2);
        pulse_stop();
        chk("ovl_done", 32'(done), 32'd1);
        // cfg_valid leaves DONE but is not accepted.
        do_cfg(8'hFF, 4'd2, 1'b0, 8'd0);
        chk("done_cfg_idle", 32'(cfg_ready), 32'd1);
        chk("done_cfg_cnt",  32'(match_cnt), 32'd2);

        // Single-bit pattern with target 3: done after third match, fourth bit ignored.
        do_cfg(8'h01, 4'd1, 1'b0, 8'd3);
        pulse_start();
        send_bit(1'b1, 1'b1, "tgt_z1");
        send_bit(1'b1, 1'b1, "tgt_z2");
        chk("tgt_busy_mid", 32'(busy), 32'd1);
        send_bit(1'b1, 1'b1, "tgt_z3");
        chk("tgt_done", 32'(done), 32'd1);
        chk("tgt_busy", 32'(busy), 32'd0);
        chk("tgt_cnt3", 32'(match_cnt), 32'd3);
        send_bit(1'b1, 1'b0, "tgt_z4");
        chk("tgt_cnt_hold", 32'(match_cnt), 32'd3);
        pulse_start();
        chk("tgt_idle", 32'(cfg_ready), 32'd1);

        // Illegal lengths 0 and 9.
        do_cfg(8'h05, 4'd0, 1'b0, 8'd0);
        chk("len0_err",   32'(err),       32'd1);
        chk("len0_ready", 32'(cfg_ready), 32'd1);
        tick();
        chk("len0_err_clear", 32'(err), 32'd0);
        do_cfg(8'h05, 4'd9, 1'b0, 8'd0);
        chk("len9_err",   32'(err),       32'd1);
        chk("len9_ready", 32'(cfg_ready), 32'd1);
        chk("len9_busy",  32'(busy),      32'd0);
        tick();
        chk("len9_err_clear", 32'(err), 32'd0);

        // x_valid gaps with junk data: only qualified bits count.
        do_cfg(8'b0110, 4'd4, 1'b0, 8'd0);
        pulse_start();
        send_bit(1'b0, 1'b0, "gap_b1");
        send_gap(1'b1);
        send_bit(1'b1, 1'b0, "gap_b2");
        send_gap(1'b0);
        send_gap(1'b0);
        send_bit(1'b1, 1'b0, "gap_b3");
        send_gap(1'b1);
        send_bit(1'b0, 1'b1, "gap_b4");
        send_gap(1'b0);
        chk("gap_cnt", 32'(match_cnt), 32'd1);
        pulse_stop();
        pulse_start();

        // Reset on the cycle the final pattern bit arrives.
        do_cfg(8'b0110, 4'd4, 1'b0, 8'd0);
        pulse_start();
        send_bit(1'b0, 1'b0, "rmid_b1");
        send_bit(1'b1, 1'b0, "rmid_b2");
        send_bit(1'b1, 1'b0, "rmid_b3");
        x       = 1'b0;
        x_valid = 1'b1;
        reset   = 1'b1;
        tick();
        x_valid = 1'b0;
        reset   = 1'b0;
        chk("rmid_z",     32'(z),         32'd0);
        chk("rmid_cnt",   32'(match_cnt), 32'd0);
        chk("rmid_ready", 32'(cfg_ready), 32'd1);
        tick();
        chk("rmid_z_after", 32'(z), 32'd0);

        // Stop in ARMED returns to IDLE.
        do_cfg(8'h01, 4'd1, 1'b0, 8'd0);
        pulse_stop();
        chk("armed_stop_idle", 32'(cfg_ready), 32'd1);

        // Stop coinciding with a match: the match still counts.
        do_cfg(8'h01, 4'd1, 1'b0, 8'd0);
        pulse_start();
        x       = 1'b1;
        x_valid = 1'b1;
        stop    = 1'b1;
        tick();
        x_valid = 1'b0;
        stop    = 1'b0;
        chk("stopm_z",    32'(z),         32'd1);
        chk("stopm_cnt",  32'(match_cnt), 32'd1);
        chk("stopm_done", 32'(done),      32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/seq_det_ctrl.md
SEQ_DET_CTRL -- requirements
Module: seq_det_ctrl

Interface
REQ-001 The block SHALL have parameter MAX_LEN, default 8, giving the maximum pattern length in bits.
REQ-002 The block SHALL have parameter CNT_W, default 8, giving the match counter and target width.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all logic is rising-edge.
REQ-004 The block SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 The block SHALL have port cfg_valid, input, 1, configuration request.
REQ-006 The block SHALL have port cfg_ready, output, 1, high only in IDLE.
REQ-007 The block SHALL have port cfg_pattern, input, MAX_LEN, the pattern; bit [cfg_len-1] is the first-received bit.
REQ-008 The block SHALL have port cfg_len, input, 4, the pattern length, legal range 1..MAX_LEN.
REQ-009 The block SHALL have port cfg_overlap, input, 1, where 1 = overlapping detection.
REQ-010 The block SHALL have port cfg_target, input, CNT_W, the match count that ends the run; 0 = run until stop.
REQ-011 The block SHALL have port start, input, 1, which arms a configured run.
REQ-012 The block SHALL have port stop, input, 1, which aborts a run.
REQ-013 The block SHALL have port x, input, 1, the serial data bit.
REQ-014 The block SHALL have port x_valid, input, 1, qualifying x; bits with x_valid=0 are ignored.
REQ-015 The block SHALL have port z, output, 1, a one-cycle match pulse.
REQ-016 The block SHALL have port match_cnt, output, CNT_W, the matches counted in the current run.
REQ-017 The block SHALL have port busy, output, 1, high in RUN.
REQ-018 The block SHALL have port done, output, 1, high in DONE.
REQ-019 The block SHALL have port err, output, 1, a one-cycle pulse on a rejected configuration.

Function
REQ-020 The FSM states SHALL be IDLE, ARMED, RUN and DONE.
REQ-021 A cfg_valid&&cfg_ready handshake with legal cfg_len SHALL latch pattern/len/overlap/target, go IDLE->ARMED, and clear match_cnt.
REQ-022 cfg_len of 0 or >MAX_LEN SHALL stay in IDLE, latch nothing, and pulse err the next cycle.
REQ-023 ARMED: start SHALL go to RUN and clear the history register and bit counter; stop SHALL return to IDLE.
REQ-024 RUN: each x_valid bit SHALL shift into history, and the bit counter SHALL increment, saturating at MAX_LEN.
REQ-025 A match SHALL be declared when the bit counter >= len and the last len history bits equal cfg_pattern[len-1:0], including the current bit.
REQ-026 z SHALL be registered, pulsing the cycle after the matching bit is sampled, giving 1-cycle latency.
REQ-027 On a match, match_cnt SHALL increment, saturating at all-ones.
REQ-028 On a match with overlap=0, the bit counter SHALL clear, so a further match needs len fresh bits.
REQ-029 On a match with overlap=1, history and the bit counter SHALL be kept.
REQ-030 When match_cnt reaches a nonzero target, the block SHALL go RUN->DONE in the same cycle z pulses; later bits are ignored.
REQ-031 stop in RUN SHALL go to DONE, with match_cnt holding its value.
REQ-032 If stop and a match occur in the same cycle, the match SHALL count and z SHALL pulse.
REQ-033 DONE SHALL return to IDLE on start or cfg_valid; that cycle's cfg_valid is not accepted (cfg_ready=0).
REQ-034 cfg_valid outside IDLE SHALL be ignored, and start outside ARMED/DONE SHALL be ignored.

Reset
REQ-035 Reset SHALL go to IDLE and zero z, match_cnt, busy, done, err, history, the bit counter and the latched configuration.
REQ-036 Reset asserted mid-RUN SHALL win over every other input, and no z SHALL appear after reset.

Structure
REQ-037 The state encoding, MAX_LEN/CNT_W defaults and the len legality check SHALL live in the shared package seq_det_pkg.
REQ-038 The shift history and masked compare SHALL be sub-module pattern_match_core (inputs: bit, shift enable, clear, pattern, len; output: hit).
REQ-039 The estimated size SHALL be about 200 lines of RTL.

Verification
REQ-040 pattern 0110, len 4, overlap 0, target 0; stream 0110110 -> one z, after bit 4; match_cnt=1.
REQ-041 Same stream with overlap 1 -> z after bits 4 and 7; match_cnt=2.
REQ-042 pattern 1, len 1, target 3; stream 1111 -> three z, DONE after the third; the fourth bit is ignored; match_cnt=3.
REQ-043 cfg_len=0, then cfg_len=9 -> err pulsed twice, cfg_ready stays 1, state stays IDLE.
REQ-044 pattern 0110, len 4; stream 011 with x_valid gaps, then 0 -> z exactly once, one cycle after the final valid bit.
REQ-045 reset asserted the same cycle the last pattern bit arrives -> no z, match_cnt=0, state IDLE.
